// File: rtl/ct_sysio_pkg.sv
// Shared constants for the sysio machine-timer generator.
// Widths, tick-source and write-half selectors.
package ct_sysio_pkg;

  localparam int CNT_WIDTH = 64;
  localparam int DIV_WIDTH = 8;

  localparam logic TICK_SRC_INT = 1'b0;
  localparam logic TICK_SRC_EXT = 1'b1;

  localparam logic WR_LO = 1'b0;
  localparam logic WR_HI = 1'b1;

endpackage

// File: rtl/ct_sysio_tick_sync.sv
// Pad tick synchronizer: two sync flops plus an edge-detect flop.
// o_rise is high for one cycle per captured rising edge.
module ct_sysio_tick_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Shift the pad level through the sync chain every cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pad;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/ct_sysio_mtime_gen.sv
// 64-bit free-running mtime generator for the CLINT.
// Internal prescaler or external pad tick; atomic lo/hi load.
module ct_sysio_mtime_gen
  import ct_sysio_pkg::*;
(
  input  logic                 forever_cpuclk,
  input  logic                 cpurst,
  input  logic                 sysio_mtime_en,
  input  logic                 sysio_dbg_halt,
  input  logic                 sysio_tick_sel,
  input  logic [DIV_WIDTH-1:0] sysio_div_val,
  input  logic                 pad_sysio_tick,
  input  logic                 sysio_wr_vld,
  input  logic                 sysio_wr_hi,
  input  logic [31:0]          sysio_wr_data,
  output logic [CNT_WIDTH-1:0] sysio_clint_mtime,
  output logic                 sysio_mtime_tick,
  output logic                 sysio_mtime_wrap,
  output logic                 sysio_mtime_wr_pend
);

  logic                 w_active;
  logic                 w_rise;
  logic                 w_ext_tick;
  logic                 w_int_tick;
  logic                 w_tick;
  logic                 w_commit;
  logic                 w_wr_lo;
  logic                 w_sel_int;
  logic                 w_pre_hit;

  logic [DIV_WIDTH-1:0] r_pre_cnt;
  logic [CNT_WIDTH-1:0] r_mtime;
  logic [31:0]          r_stage_lo;
  logic                 r_pend;
  logic                 r_tick;
  logic                 r_wrap;

  ct_sysio_tick_sync u_sync (
    .i_clk  (forever_cpuclk),
    .i_rst  (cpurst),
    .i_pad  (pad_sysio_tick),
    .o_rise (w_rise)
  );

  assign w_active   = sysio_mtime_en & ~sysio_dbg_halt;
  assign w_sel_int  = (sysio_tick_sel == TICK_SRC_INT);
  assign w_pre_hit  = (r_pre_cnt >= sysio_div_val);
  assign w_int_tick = w_active & w_sel_int & w_pre_hit;
  assign w_ext_tick = w_active & ~w_sel_int & w_rise;
  assign w_tick     = w_int_tick | w_ext_tick;
  assign w_commit   = sysio_wr_vld & (sysio_wr_hi == WR_HI);
  assign w_wr_lo    = sysio_wr_vld & (sysio_wr_hi == WR_LO);

  // Prescaler: wrap at div_val while active, parked at 0 on pad source
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_pre_cnt <= '0;
    end else if (!w_sel_int) begin
      r_pre_cnt <= '0;
    end else if (w_active) begin
      if (w_pre_hit) r_pre_cnt <= '0;
      else           r_pre_cnt <= r_pre_cnt + DIV_WIDTH'(1);
    end
  end

  // Counter: a high-half commit wins over a same-cycle tick
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_mtime <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_commit) begin
      r_mtime <= {sysio_wr_data, r_stage_lo};
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + CNT_WIDTH'(1);
      r_tick  <= 1'b1;
      r_wrap  <= &r_mtime;
    end else begin
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end
  end

  // Write staging: low half parks here until the high half commits
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_stage_lo <= '0;
      r_pend     <= 1'b0;
    end else if (w_wr_lo) begin
      r_stage_lo <= sysio_wr_data;
      r_pend     <= 1'b1;
    end else if (w_commit) begin
      r_pend     <= 1'b0;
    end
  end

  assign sysio_clint_mtime   = r_mtime;
  assign sysio_mtime_tick    = r_tick;
  assign sysio_mtime_wrap    = r_wrap;
  assign sysio_mtime_wr_pend = r_pend;

endmodule

// File: doc/ct_sysio_mtime_gen.md
Name: ct_sysio_mtime_gen

Overview:
- System-level 64-bit machine-timer generator that produces sysio_clint_mtime, the free-running time base consumed by the CLINT for mtimecmp comparison and timer interrupts.
- Counts ticks from an internal prescaler or from an asynchronous external reference tick.
- Supports atomic 64-bit software load through two 32-bit writes.
- Supports enable and debug-halt gating.

Parameters:
- CNT_WIDTH, 64, mtime counter width; fixed at 64 for CLINT compatibility.
- DIV_WIDTH, 8, prescaler terminal-value width.

Ports:
- forever_cpuclk  in  1  sole clock.
- cpurst  in  1  reset; one clock; reset is synchronous and active-high.
- sysio_mtime_en  in  1  count enable.
- sysio_dbg_halt  in  1  debug halt; freezes counting.
- sysio_tick_sel  in  1  tick source: 0 = internal prescaler, 1 = external pad tick.
- sysio_div_val  in  DIV_WIDTH  prescaler terminal value; one tick every div_val+1 cycles.
- pad_sysio_tick  in  1  asynchronous external reference; rising edge = one tick.
- sysio_wr_vld  in  1  write strobe, single cycle.
- sysio_wr_hi  in  1  write select: 0 = low half, 1 = high half.
- sysio_wr_data  in  32  write data.
- sysio_clint_mtime  out  CNT_WIDTH  current time value, registered.
- sysio_mtime_tick  out  1  one-cycle pulse, coincident with each increment.
- sysio_mtime_wrap  out  1  one-cycle pulse when mtime wraps from all-ones to 0.
- sysio_mtime_wr_pend  out  1  low half staged, awaiting high-half commit.

Behaviour:
- Reset (cpurst=1 at an edge) clears:
  - mtime and the prescaler counter;
  - the sync flops s1/s2/s3;
  - stage_lo and the pending flag;
  - the tick and wrap outputs.
- Reset mid-operation discards any pending staged write.
- active = sysio_mtime_en & ~sysio_dbg_halt.
- Internal source (sel=0), while active:
  - if pre_cnt >= div_val: pre_cnt <= 0 and a tick is raised;
  - otherwise pre_cnt <= pre_cnt + 1.
  - Using >= means that lowering div_val below pre_cnt produces a tick on the next cycle; no tick is missed.
  - Inactive: pre_cnt holds.
  - sel=1: pre_cnt is held at 0.
  - div_val=0 gives a tick every cycle.
- External source (sel=1):
  - pad_sysio_tick is captured in s1, then s2, then s3 on every edge, regardless of sel.
  - raw_tick = s2 & ~s3 & active.
  - A pad rise captured at edge N raises raw_tick during cycle N+1..N+2; mtime increments at edge N+2.
  - Because the edge detector runs continuously, switching sel never creates a spurious tick.
  - A pad level held high produces exactly one tick.
- Increment:
  - On a tick with no commit: mtime <= mtime + 1, modulo 2^64, and sysio_mtime_tick=1 for the following cycle.
  - If the pre-increment mtime was all-ones, sysio_mtime_wrap=1 in the same cycle as the tick pulse.
- Write of the low half (wr_vld & ~wr_hi): stage_lo <= data and pending <= 1. mtime is unchanged.
- Write of the high half (wr_vld & wr_hi): mtime <= {data, stage_lo} and pending <= 0.
  - Without a prior low write, the commit uses the retained stage_lo (0 after reset).
- Same cycle as a tick:
  - A high-half commit has priority; that tick is discarded, with no increment and no tick/wrap pulse.
  - A low-half write does not block the tick.
- Writes are always accepted; there is no back-pressure.
- The next increment after a commit happens no earlier than the edge following the commit.

Decomposition:
- Shared package ct_sysio_pkg:
  - CNT_WIDTH and DIV_WIDTH;
  - localparams TICK_SRC_INT=0 and TICK_SRC_EXT=1;
  - WR_LO=0 and WR_HI=1.
- One sub-module, ct_sysio_tick_sync: the 2-flop synchronizer plus the edge-detect flop. It outputs a rise pulse and has synchronous active-high reset.
- The prescaler, counter and write staging stay in the top module.

Test Plan:
1. Reset, then en=1, sel=0, div_val=3 for 40 cycles -> mtime=10; tick pulse every 4th cycle; wrap=0.
2. div_val=0 with dbg_halt=1 for 5 cycles mid-count -> mtime frozen for exactly 5 cycles; counting then resumes at +1 per cycle; pre_cnt value preserved.
3. div_val=0:
   - write lo 0xFFFFFFFE, then hi 0xFFFFFFFF -> wr_pend 1 then 0;
   - mtime=0xFFFF_FFFF_FFFF_FFFE after the commit edge;
   - two ticks later mtime=0 with wrap=1 for one cycle.
4. sel=1; pad toggled high 4 cycles / low 4 cycles, 5 times -> mtime +5; each tick pulse appears 3 edges after the pad rise; no double counts.
5. div_val=0; high write of 0x12345678 with stage_lo=0 in a tick cycle -> mtime=0x12345678_00000000 exactly, with no increment and no tick pulse that cycle; +1 on the following edge.
6. Stage lo 0xAAAA5555, assert cpurst for 1 cycle, then high write 0x1 -> wr_pend=0 after reset; mtime=0x00000001_00000000.
